// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern detector and its alert controller.
// Holds the controller state encoding, the detector's pattern bytes and defaults.
package pattern_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_HOLD     = 3'd2,
        ST_WAIT_CLR = 3'd3,
        ST_RELEASE  = 3'd4
    } alert_state_t;

    // ASCII bytes of the sequence the upstream detector looks for
    localparam logic [7:0] PAT_BYTE0 = 8'h62;
    localparam logic [7:0] PAT_BYTE1 = 8'h6f;
    localparam logic [7:0] PAT_BYTE2 = 8'h6d;
    localparam logic [7:0] PAT_BYTE3 = 8'h62;

    localparam int HOLD_CYCLES_DEFAULT = 16;
    localparam int CNT_W_DEFAULT       = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear and sticky overflow.
// A clear coincident with an increment leaves the count at one.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_sync,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    always_ff @(posedge clk or negedge reset_sync) begin
        if (!reset_sync) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            count    <= inc ? CNT_W'(1) : '0;
            overflow <= 1'b0;
        end else if (inc) begin
            if (&count) begin
                overflow <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_alert_ctrl.sv
// Alert controller: latches detector hits into a held alarm, counts them,
// and returns ack to the detector only after the host clears the alarm.
module pattern_alert_ctrl
    import pattern_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_sync,
    input  logic             found_pattern,
    input  logic             arm,
    input  logic             host_clear,
    input  logic             cnt_clear,
    output logic             ack,
    output logic             alarm,
    output logic [CNT_W-1:0] event_count,
    output logic             overflow
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    alert_state_t  state;
    logic [HW-1:0] hold_cnt;
    logic          clr_pend;
    logic          det;

    // A hit is only taken while no alarm is in flight
    assign det = found_pattern &&
                 ((state == ST_IDLE) || (state == ST_ARMED));

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .reset_sync (reset_sync),
        .clear      (cnt_clear),
        .inc        (det),
        .count      (event_count),
        .overflow   (overflow)
    );

    always_ff @(posedge clk or negedge reset_sync) begin
        if (!reset_sync) begin
            state    <= ST_IDLE;
            ack      <= 1'b0;
            alarm    <= 1'b0;
            hold_cnt <= '0;
            clr_pend <= 1'b0;
        end else if (det) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_LOAD;
            clr_pend <= 1'b0;
            ack      <= 1'b0;
            alarm    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state <= ST_ARMED;
                        ack   <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (!arm) begin
                        state <= ST_IDLE;
                        ack   <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HW'(1);
                        if (host_clear) begin
                            clr_pend <= 1'b1;
                        end
                    end else if (clr_pend || host_clear) begin
                        state    <= ST_RELEASE;
                        ack      <= 1'b1;
                        alarm    <= 1'b0;
                        clr_pend <= 1'b0;
                    end else begin
                        state <= ST_WAIT_CLR;
                    end
                end
                ST_WAIT_CLR: begin
                    if (host_clear) begin
                        state <= ST_RELEASE;
                        ack   <= 1'b1;
                        alarm <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    // Detector drops found_pattern a cycle after seeing ack
                    if (!found_pattern) begin
                        state <= arm ? ST_ARMED : ST_IDLE;
                        ack   <= arm;
                        alarm <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ack      <= 1'b0;
                    alarm    <= 1'b0;
                    hold_cnt <= '0;
                    clr_pend <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_alert_ctrl.sv
// Randomized and directed bench for pattern_alert_ctrl against an
// alarm-lifecycle reference model (HOLD_CYCLES=4, CNT_W=2).
module tb_pattern_alert_ctrl;

    localparam int HOLD = 4;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          reset_sync = 1'b0;
    logic          found_pattern = 1'b0;
    logic          arm = 1'b0;
    logic          host_clear = 1'b0;
    logic          cnt_clear = 1'b0;
    logic          ack;
    logic          alarm;
    logic [CW-1:0] event_count;
    logic          overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: alarm lifetime measured in edges since the hit
    bit m_ack, m_alarm, m_rel, m_clr_seen, m_ovf;
    int m_age, m_cnt;

    pattern_alert_ctrl #(
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CW)
    ) dut (
        .clk           (clk),
        .reset_sync    (reset_sync),
        .found_pattern (found_pattern),
        .arm           (arm),
        .host_clear    (host_clear),
        .cnt_clear     (cnt_clear),
        .ack           (ack),
        .alarm         (alarm),
        .event_count   (event_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ack"}, 32'(ack), 32'(m_ack));
        chk({tag, ".alarm"}, 32'(alarm), 32'(m_alarm));
        chk({tag, ".count"}, 32'(event_count), 32'(m_cnt));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic model_reset();
        m_ack = 0; m_alarm = 0; m_rel = 0; m_clr_seen = 0;
        m_ovf = 0; m_age = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit fp, input bit a,
                              input bit hc, input bit cc);
        bit det;
        det = fp && !m_alarm && !m_rel;
        if (cc) begin
            m_cnt = 0;
            m_ovf = 0;
        end
        if (det) begin
            if (m_cnt == CMAX) m_ovf = 1;
            else m_cnt = m_cnt + 1;
            m_alarm = 1; m_ack = 0; m_age = 0; m_clr_seen = 0;
        end else if (m_alarm) begin
            m_age = m_age + 1;
            if (m_age < HOLD) begin
                m_clr_seen = m_clr_seen | hc;
            end else if (m_clr_seen || hc) begin
                m_alarm = 0; m_ack = 1; m_rel = 1;
            end
        end else if (m_rel) begin
            if (!fp) begin
                m_rel = 0;
                m_ack = a;
            end
        end else begin
            m_ack = a;
        end
    endtask

    task automatic cycle(input bit fp, input bit a, input bit hc,
                         input bit cc, input string tag);
        @(negedge clk);
        found_pattern = fp; arm = a; host_clear = hc; cnt_clear = cc;
        @(posedge clk);
        model_step(fp, a, hc, cc);
        #1;
        check_all(tag);
    endtask

    task automatic zero_inputs();
        found_pattern = 0; arm = 0; host_clear = 0; cnt_clear = 0;
    endtask

    initial begin
        int hi;
        bit fp, a, hc, cc;

        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        reset_sync = 1'b1;

        // arm, then a full detection with a late host clear
        cycle(0, 1, 0, 0, "arm");
        chk("arm_ack", 32'(ack), 32'd1);
        cycle(1, 1, 0, 0, "det");
        chk("det_alarm", 32'(alarm), 32'd1);
        chk("det_cnt", 32'(event_count), 32'd1);
        repeat (5) cycle(1, 1, 0, 0, "hold");
        cycle(1, 1, 1, 0, "late_clr");
        chk("rel_ack", 32'(ack), 32'd1);
        cycle(1, 1, 0, 0, "rel_stay");
        cycle(0, 1, 0, 0, "to_armed");

        // early clear inside HOLD: alarm high exactly HOLD cycles
        cycle(1, 1, 0, 0, "det2");
        hi = 1;
        cycle(1, 1, 1, 0, "early_clr");
        if (alarm) hi++;
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, 0, 0, "hold2");
            if (alarm) hi++;
        end
        chk("hold_len", 32'(hi), 32'(HOLD));
        cycle(0, 1, 0, 0, "armed2");

        // saturation and overflow, then clear coincident with a hit
        cycle(0, 1, 0, 1, "cclr");
        for (int k = 0; k < 5; k++) begin
            cycle(1, 1, 0, (k == 4), "sat_det");
            if (k == 2) chk("cnt_sat", 32'(event_count), 32'd3);
            if (k == 3) chk("ovf_set", 32'(overflow), 32'd1);
            if (k == 4) begin
                chk("cclr_cnt", 32'(event_count), 32'd1);
                chk("cclr_ovf", 32'(overflow), 32'd0);
            end
            cycle(1, 1, 1, 0, "sat_clr");
            repeat (4) cycle(1, 1, 0, 0, "sat_hold");
            cycle(0, 1, 0, 0, "sat_idle");
        end

        // disarm during HOLD, then hit straight from IDLE
        cycle(1, 1, 0, 0, "det3");
        repeat (5) cycle(1, 0, 0, 0, "disarm");
        chk("disarm_alarm", 32'(alarm), 32'd1);
        cycle(1, 0, 1, 0, "clr3");
        cycle(0, 0, 0, 0, "to_idle");
        chk("idle_ack", 32'(ack), 32'd0);
        cycle(1, 0, 0, 0, "idle_det");
        chk("idle_det_alarm", 32'(alarm), 32'd1);

        // async reset while waiting for a clear
        repeat (6) cycle(1, 0, 0, 0, "wait_clr");
        @(negedge clk);
        zero_inputs();
        #2 reset_sync = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset_sync = 1'b1;
        cycle(0, 1, 0, 0, "rearm");
        chk("rearm_ack", 32'(ack), 32'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (m_rel) fp = ($urandom_range(0, 1) == 0);
            else fp = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 3) != 0);
            hc = ($urandom_range(0, 5) == 0);
            cc = ($urandom_range(0, 39) == 0);
            cycle(fp, a, hc, cc, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
